// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU operation sequencer.
// Defining ALU_SEQ_ACC_EN adds the accumulator flag to the stored command.
package alu_seq_pkg;

  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_RESP  = 2'b10
  } state_e;

  typedef struct packed {
`ifdef ALU_SEQ_ACC_EN
    logic              acc;
`endif
    alu_op_e           op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command, ALU-drive and response signals of the sequencer.
// The slave modport is the sequencer's view; master is the environment's.
interface alu_op_sequencer_if;
  import alu_seq_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [1:0]        cmd_op;
  logic              cmd_acc;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [1:0]        alu_op;
  logic [DATA_W-1:0] alu_y;
  logic              alu_carry;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_y;
  logic              rsp_carry;
  logic              busy;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_acc, alu_y, alu_carry, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_y, rsp_carry, busy
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_acc, alu_y, alu_carry, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_y, rsp_carry, busy
  );

endinterface

// File: rtl/alu_seq_fifo.sv
// Command FIFO with show-ahead head output so the sequencer can pop and issue
// in the same cycle. DEPTH must be a power of two (2..16); pointers wrap naturally.
module alu_seq_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = alu_seq_pkg::cmd_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  T     data_i,
  output logic full_o,
  input  logic pop_i,
  output T     data_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  // A full FIFO refuses the push even when the head leaves in the same cycle.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Queues ALU commands, drives an external combinational ALU and returns results.
// Defining ALU_SEQ_ACC_EN enables the accumulator operand path.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  alu_op_sequencer_if.slave bus
);

  cmd_t              push_data;
  cmd_t              head;
  logic              full;
  logic              empty;
  logic              pop;
  logic [DATA_W-1:0] issue_a_d;

  state_e            state_q;
  logic [DATA_W-1:0] alu_a_q;
  logic [DATA_W-1:0] alu_b_q;
  logic [1:0]        alu_op_q;
  logic [DATA_W-1:0] rsp_y_q;
  logic              rsp_carry_q;
  logic              rsp_valid_q;
`ifdef ALU_SEQ_ACC_EN
  logic [DATA_W-1:0] acc_q;
`else
  logic              unused_cmd_acc;
  assign unused_cmd_acc = bus.cmd_acc;
`endif

  always_comb begin
    push_data    = '0;
    push_data.op = alu_op_e'(bus.cmd_op);
    push_data.a  = bus.cmd_a;
    push_data.b  = bus.cmd_b;
`ifdef ALU_SEQ_ACC_EN
    push_data.acc = bus.cmd_acc;
`endif
  end

  alu_seq_fifo #(.DEPTH(DEPTH), .T(cmd_t)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (bus.cmd_valid),
    .data_i (push_data),
    .full_o (full),
    .pop_i  (pop),
    .data_o (head),
    .empty_o(empty)
  );

  // The head is popped either from IDLE or straight out of RESP on a handshake.
  always_comb begin
    pop = 1'b0;
    case (state_q)
      ST_IDLE: pop = !empty;
      ST_RESP: pop = bus.rsp_ready && !empty;
      default: pop = 1'b0;
    endcase
    issue_a_d = head.a;
`ifdef ALU_SEQ_ACC_EN
    if (head.acc) issue_a_d = acc_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_y_q     <= '0;
      rsp_carry_q <= 1'b0;
      rsp_valid_q <= 1'b0;
`ifdef ALU_SEQ_ACC_EN
      acc_q       <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            alu_a_q  <= issue_a_d;
            alu_b_q  <= head.b;
            alu_op_q <= head.op;
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          rsp_y_q     <= bus.alu_y;
          rsp_carry_q <= bus.alu_carry;
`ifdef ALU_SEQ_ACC_EN
          acc_q       <= bus.alu_y;
`endif
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (pop) begin
              alu_a_q  <= issue_a_d;
              alu_b_q  <= head.b;
              alu_op_q <= head.op;
              state_q  <= ST_ISSUE;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = !full;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_y     = rsp_y_q;
  assign bus.rsp_carry = rsp_carry_q;
  assign bus.busy      = (state_q != ST_IDLE) || !empty;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural ALU and result model.
// Build with ALU_SEQ_ACC_EN defined to exercise the accumulator variant.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run    = 0;
  int   tests_failed = 0;

  logic [3:0] model_acc = '0;
  logic [4:0] exp_q[$];
  logic [4:0] alu_wide;

  alu_op_sequencer_if bus();

  alu_op_sequencer #(.DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // External combinational ALU
  always_comb begin
    case (bus.alu_op)
      2'd0:    alu_wide = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      2'd1:    alu_wide = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      2'd2:    alu_wide = {1'b0, bus.alu_a & bus.alu_b};
      default: alu_wide = {1'b0, bus.alu_a | bus.alu_b};
    endcase
  end
  assign bus.alu_y     = alu_wide[3:0];
  assign bus.alu_carry = alu_wide[4];

  // Expected {carry, y} of the command currently presented on the bus.
  function automatic void model_push();
    int   opa;
    int   r;
    logic c;
    opa = int'(bus.cmd_a);
`ifdef ALU_SEQ_ACC_EN
    if (bus.cmd_acc) opa = int'(model_acc);
`endif
    case (int'(bus.cmd_op))
      0:       begin r = opa + int'(bus.cmd_b); c = (r > 15); end
      1:       begin r = opa - int'(bus.cmd_b); c = (r < 0);  end
      2:       begin r = opa & int'(bus.cmd_b); c = 1'b0;     end
      default: begin r = opa | int'(bus.cmd_b); c = 1'b0;     end
    endcase
    model_acc = 4'(r & 15);
    exp_q.push_back({c, 4'(r & 15)});
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_op = '0;
    bus.cmd_acc = 1'b0; bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready);
    end
    tests_run++;
    if ({bus.rsp_valid, bus.busy, bus.alu_a, bus.alu_b, bus.alu_op, bus.rsp_y, bus.rsp_carry} !== 17'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h expected 0",
               {bus.rsp_valid, bus.busy, bus.alu_a, bus.alu_b, bus.alu_op, bus.rsp_y, bus.rsp_carry});
    end
    rst_n = 1'b1;
    model_acc = '0;
    exp_q.delete();
    @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release_busy: got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_directed();
    int ta[4] = '{9, 3, 12, 12};
    int tb[4] = '{8, 5, 10, 10};
    int to[4] = '{0, 1, 2, 3};
    int ty[4] = '{1, 14, 8, 14};
    int tc[4] = '{1, 1, 0, 0};
    logic [9:0] exp_drive;
    for (int i = 0; i < 4; i++) begin
      bus.cmd_valid = 1'b1; bus.cmd_a = 4'(ta[i]); bus.cmd_b = 4'(tb[i]);
      bus.cmd_op = 2'(to[i]); bus.cmd_acc = 1'b0; bus.rsp_ready = 1'b0;
      exp_drive = {4'(ta[i]), 4'(tb[i]), 2'(to[i])};
      tests_run++;
      if (bus.cmd_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL dir%0d_ready: got %b expected 1", i, bus.cmd_ready);
      end
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      tests_run++;
      if ({bus.rsp_valid, bus.busy} !== 2'b01) begin
        tests_failed++;
        $display("FAIL dir%0d_after_n: got valid,busy=%b expected 01", i, {bus.rsp_valid, bus.busy});
      end
      @(negedge clk);
      tests_run++;
      if ({bus.alu_a, bus.alu_b, bus.alu_op} !== exp_drive || bus.rsp_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL dir%0d_alu_drive: got %h valid %b expected %h valid 0",
                 i, {bus.alu_a, bus.alu_b, bus.alu_op}, bus.rsp_valid, exp_drive);
      end
      @(negedge clk);
      tests_run++;
      if (bus.rsp_valid !== 1'b1 || {bus.rsp_carry, bus.rsp_y} !== {1'(tc[i]), 4'(ty[i])}) begin
        tests_failed++;
        $display("FAIL dir%0d_rsp: got valid %b c/y %h expected valid 1 c/y %h",
                 i, bus.rsp_valid, {bus.rsp_carry, bus.rsp_y}, {1'(tc[i]), 4'(ty[i])});
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      tests_run++;
      if ({bus.rsp_valid, bus.busy} !== 2'b00 || {bus.alu_a, bus.alu_b, bus.alu_op} !== exp_drive) begin
        tests_failed++;
        $display("FAIL dir%0d_done: got valid,busy=%b drive %h expected 00 drive %h",
                 i, {bus.rsp_valid, bus.busy}, {bus.alu_a, bus.alu_b, bus.alu_op}, exp_drive);
      end
      model_acc = 4'(ty[i]);
    end
  endtask

  task automatic test_acc();
    logic [4:0] exp_r[2];
    int         got;
    exp_r[0] = 5'h05;
`ifdef ALU_SEQ_ACC_EN
    exp_r[1] = 5'h09;
`else
    exp_r[1] = 5'h04;
`endif
    bus.rsp_ready = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_a = 4'd2; bus.cmd_b = 4'd3; bus.cmd_op = 2'd0; bus.cmd_acc = 1'b0;
    @(negedge clk);
    bus.cmd_a = 4'd0; bus.cmd_b = 4'd4; bus.cmd_acc = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0; bus.cmd_acc = 1'b0;
    got = 0;
    for (int c = 0; c < 20 && got < 2; c++) begin
      if (bus.rsp_valid) begin
        tests_run++;
        if ({bus.rsp_carry, bus.rsp_y} !== exp_r[got]) begin
          tests_failed++;
          $display("FAIL acc_rsp%0d: got %h expected %h", got, {bus.rsp_carry, bus.rsp_y}, exp_r[got]);
        end
        got++;
      end
      @(negedge clk);
    end
    tests_run++;
    if (got != 2) begin
      tests_failed++;
      $display("FAIL acc_count: got %0d responses expected 2", got);
    end
    bus.rsp_ready = 1'b0;
    model_acc = exp_r[1][3:0];
  endtask

  task automatic test_full();
    int         accepts;
    logic [4:0] e;
    bus.rsp_ready = 1'b0;
    accepts = 0;
    for (int c = 0; c < 12; c++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_a = 4'($urandom_range(0, 15)); bus.cmd_b = 4'($urandom_range(0, 15));
      bus.cmd_op = 2'($urandom_range(0, 3)); bus.cmd_acc = 1'($urandom_range(0, 1));
      if (bus.cmd_ready) begin
        model_push();
        accepts++;
      end
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    tests_run++;
    if (accepts != DEPTH + 1 || bus.cmd_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_accepts: got %0d accepts ready %b expected %0d ready 0",
               accepts, bus.cmd_ready, DEPTH + 1);
    end
    tests_run++;
    if (bus.rsp_valid !== 1'b1 || {bus.rsp_carry, bus.rsp_y} !== exp_q[0]) begin
      tests_failed++;
      $display("FAIL full_held_rsp: got valid %b c/y %h expected valid 1 c/y %h",
               bus.rsp_valid, {bus.rsp_carry, bus.rsp_y}, exp_q[0]);
    end
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      if (bus.rsp_valid) begin
        e = exp_q.pop_front();
        tests_run++;
        if ({bus.rsp_carry, bus.rsp_y} !== e) begin
          tests_failed++;
          $display("FAIL full_drain: got %h expected %h", {bus.rsp_carry, bus.rsp_y}, e);
        end
      end
      @(negedge clk);
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL full_lost: got %0d missing responses expected 0", exp_q.size());
      exp_q.delete();
    end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_random(input int cycles);
    logic       held;
    logic [4:0] held_val;
    logic [4:0] e;
    held = 1'b0;
    held_val = '0;
    for (int c = 0; c < cycles; c++) begin
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      if (bus.rsp_valid) begin
        if (held) begin
          tests_run++;
          if ({bus.rsp_carry, bus.rsp_y} !== held_val) begin
            tests_failed++;
            $display("FAIL rand_stable: got %h expected %h", {bus.rsp_carry, bus.rsp_y}, held_val);
          end
        end
        if (bus.rsp_ready) begin
          held = 1'b0;
          tests_run++;
          if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL rand_extra: got %h expected no response", {bus.rsp_carry, bus.rsp_y});
          end else begin
            e = exp_q.pop_front();
            if ({bus.rsp_carry, bus.rsp_y} !== e) begin
              tests_failed++;
              $display("FAIL rand_rsp: got %h expected %h", {bus.rsp_carry, bus.rsp_y}, e);
            end
          end
        end else begin
          held = 1'b1;
          held_val = {bus.rsp_carry, bus.rsp_y};
        end
      end else begin
        held = 1'b0;
      end
      bus.cmd_valid = 1'($urandom_range(0, 1));
      bus.cmd_a = 4'($urandom_range(0, 15)); bus.cmd_b = 4'($urandom_range(0, 15));
      bus.cmd_op = 2'($urandom_range(0, 3)); bus.cmd_acc = 1'($urandom_range(0, 1));
      if (bus.cmd_valid && bus.cmd_ready) model_push();
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 80 && exp_q.size() > 0; c++) begin
      if (bus.rsp_valid) begin
        e = exp_q.pop_front();
        tests_run++;
        if ({bus.rsp_carry, bus.rsp_y} !== e) begin
          tests_failed++;
          $display("FAIL rand_drain: got %h expected %h", {bus.rsp_carry, bus.rsp_y}, e);
        end
      end
      @(negedge clk);
    end
    tests_run++;
    if (exp_q.size() != 0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rand_end: got %0d missing busy %b expected 0 missing busy 0", exp_q.size(), bus.busy);
      exp_q.delete();
    end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int waited;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_a = 4'(i + 1); bus.cmd_b = 4'(i); bus.cmd_op = 2'd0; bus.cmd_acc = 1'b0;
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    waited = 0;
    while (!bus.rsp_valid && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    tests_run++;
    if ({bus.rsp_valid, bus.busy} !== 2'b11) begin
      tests_failed++;
      $display("FAIL mid_resp_state: got valid,busy=%b expected 11", {bus.rsp_valid, bus.busy});
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.rsp_valid, bus.busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL mid_async_drop: got valid,busy=%b expected 00", {bus.rsp_valid, bus.busy});
    end
    exp_q.delete();
    model_acc = '0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tests_run++;
      if ({bus.rsp_valid, bus.busy} !== 2'b00) begin
        tests_failed++;
        $display("FAIL mid_stale_%0d: got valid,busy=%b expected 00", c, {bus.rsp_valid, bus.busy});
      end
    end
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_acc();
    test_full();
    test_random(300);
    test_reset_mid();
    test_random(200);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO entries; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  command FIFO can accept.
REQ-006 cmd_a, cmd_b  input  4 each  operands.
REQ-007 cmd_op  input  2  opcode: 00=ADD, 01=SUB, 10=AND, 11=OR.
REQ-008 cmd_acc  input  1  use accumulator as operand A (see Configuration).
REQ-009 alu_a, alu_b  output  4 each; alu_op  output  2  registered drive to the external combinational ALU.
REQ-010 alu_y  input  4; alu_carry  input  1  ALU result.
REQ-011 rsp_valid  output  1; rsp_ready  input  1  response handshake.
REQ-012 rsp_y  output  4; rsp_carry  output  1  captured result.
REQ-013 busy  output  1  high whenever the FSM is not IDLE or the FIFO is non-empty.

Function
REQ-014 Command accepted only on a cycle with cmd_valid && cmd_ready; {acc, op, a, b} pushed into the FIFO.
REQ-015 cmd_ready SHALL equal !full; a push SHALL be refused when full, even if a pop occurs the same cycle.
REQ-016 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the occupancy unchanged; read/write pointers SHALL wrap modulo DEPTH.
REQ-017 FSM states: IDLE, ISSUE, RESP.
REQ-018 IDLE: if the FIFO is non-empty, pop the head, register it onto alu_a/alu_b/alu_op, and go to ISSUE; otherwise stay.
REQ-019 ISSUE (exactly one cycle): capture alu_y and alu_carry into rsp_y/rsp_carry, and go to RESP.
REQ-020 RESP: rsp_valid = 1; rsp_y and rsp_carry SHALL stay stable until rsp_ready.
REQ-021 RESP exit on handshake: pop the next command and go directly to ISSUE if the FIFO is non-empty, else go to IDLE.
REQ-022 Latency: with an empty FIFO and IDLE state, a command accepted at edge N SHALL be in the FIFO after N, have alu_* driven after N+1, and show rsp_valid after N+2.
REQ-023 alu_a/alu_b/alu_op SHALL hold their last issued values outside ISSUE.
REQ-024 The block SHALL pass carry through unmodified: ADD carry-out, SUB borrow (5-bit wrap), AND/OR always 0 from the ALU.

Reset
REQ-025 With rst_n low: FIFO empty, state IDLE, and cmd_ready = 1 (the FIFO is empty); rsp_valid, busy, alu_a, alu_b, alu_op, rsp_y, rsp_carry and the accumulator all 0.
REQ-026 Reset asserted mid-operation SHALL discard all queued and in-flight commands, with no response emitted.

Configuration
REQ-027 Macro ALU_SEQ_ACC_EN defined: a 4-bit accumulator SHALL load rsp_y at every ISSUE capture; when a popped command has cmd_acc = 1, alu_a SHALL be the accumulator value at issue time instead of cmd_a.
REQ-028 Macro undefined: no accumulator register; cmd_acc is ignored and not stored; alu_a always comes from cmd_a.

Structure
REQ-029 Package alu_seq_pkg SHALL hold: the 4-bit data width constant, the opcode enum (ADD/SUB/AND/OR), the FSM state enum, and the packed command struct.
REQ-030 The FIFO SHALL be a sub-module, alu_seq_fifo, parameterised by DEPTH and the command struct.

Verification
REQ-031 ADD a=9 b=8 -> rsp_y=0x1, rsp_carry=1, with rsp_valid two cycles after acceptance.
REQ-032 SUB a=3 b=5 -> rsp_y=0xE, rsp_carry=1; AND a=0xC b=0xA -> 0x8, carry 0; OR a=0xC b=0xA -> 0xE, carry 0.
REQ-033 rsp_ready held low, push DEPTH+1 commands -> cmd_ready low after 1+DEPTH accepts; release rsp_ready -> responses in order, none lost.
REQ-034 With ALU_SEQ_ACC_EN: ADD 2+3 then ADD acc=1 b=4 -> responses 0x5 then 0x9; without the macro the same stimulus (cmd_a=0) -> 0x5 then 0x4.
REQ-035 Assert rst_n low while in RESP with 2 commands queued -> rsp_valid drops immediately; after release, busy=0 and no stale response appears.
